// File: rtl/dmem_store_buffer_if.sv
// Backing-memory request/ack bus between the store buffer and the data memory.
// Ports: mem_req/mem_we/mem_addr/mem_wdata from requester; mem_ack/mem_rdata from memory.
// Request fields are held stable until mem_ack; mem_ack is a one-cycle completion pulse.
interface dmem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Data-memory front end: FIFO store buffer with youngest-match load forwarding, background drain.
// Latency: stores and load hits 0 stall cycles; load miss = memory latency + 1 (+ any drain in flight).
// Backpressure: cpu_stall on full-buffer store without a same-cycle drain ack, or on a load miss.
// Ports: clock/reset, cpu_* MEM-stage request, mem (master side of the memory bus), wb_count/wb_empty.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [AW-1:0]         cpu_addr,
  input  logic [DW-1:0]         cpu_wdata,
  output logic [DW-1:0]         cpu_rdata,
  output logic                  cpu_stall,
  dmem_store_buffer_if.master   mem,
  output logic [CW-1:0]         wb_count,
  output logic                  wb_empty
);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, LOAD_DONE} state_t;

  state_t        state;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_nxt;
  logic          req_q, we_q;
  logic [AW-1:0] maddr_q;
  logic [DW-1:0] mwdata_q, rdata_q;

  logic          hit, hit_ok, load_miss, store_req, full, drain_ack, enq, deq;
  logic [DW-1:0] hit_data;

  // Scan oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && addr_q[head + PW'(i)] == cpu_addr) begin
        hit      = 1'b1;
        hit_data = data_q[head + PW'(i)];
      end
    end
  end

  // A simultaneous rd/wr is treated as a load; the store half is dropped.
  assign store_req = cpu_wr && !cpu_rd;
  assign hit_ok    = hit && (state != LOAD);
  assign load_miss = cpu_rd && !hit;
  assign full      = (count == CW'(DEPTH));
  assign drain_ack = (state == DRAIN) && req_q && mem.mem_ack;
  // A full buffer still takes a store when the head retires at the same edge.
  assign enq       = store_req && (!full || drain_ack);
  assign deq       = drain_ack;
  assign count_nxt = count + CW'(enq) - CW'(deq);

  assign cpu_stall = cpu_rd ? !(hit_ok || state == LOAD_DONE) : (store_req && !enq);
  assign cpu_rdata = hit_ok ? hit_data : rdata_q;
  assign wb_count  = count;
  assign wb_empty  = (count == '0);

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = mwdata_q;

  // Entry storage needs no reset: validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[tail] <= cpu_addr;
      data_q[tail] <= cpu_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count <= count_nxt;

      case (state)
        // Decisions use count before this cycle's enqueue, so head is always a stored entry.
        IDLE: begin
          if (load_miss) begin
            state   <= LOAD;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            maddr_q <= cpu_addr;
          end else if (count != '0) begin
            state    <= DRAIN;
            req_q    <= 1'b1;
            we_q     <= 1'b1;
            maddr_q  <= addr_q[head];
            mwdata_q <= data_q[head];
          end
        end
        DRAIN: begin
          if (req_q) begin
            if (mem.mem_ack) begin
              req_q <= 1'b0;
              if (load_miss)             state <= LOAD;
              else if (count_nxt == '0)  state <= IDLE;
            end
          end else if (load_miss) begin
            // Idle gap between drains: a newly arrived miss goes first.
            state   <= LOAD;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            maddr_q <= cpu_addr;
          end else begin
            req_q    <= 1'b1;
            we_q     <= 1'b1;
            maddr_q  <= addr_q[head];
            mwdata_q <= data_q[head];
          end
        end
        LOAD: begin
          if (req_q) begin
            if (mem.mem_ack) begin
              req_q   <= 1'b0;
              rdata_q <= mem.mem_rdata;
              state   <= LOAD_DONE;
            end
          end else if (load_miss) begin
            // Entered from DRAIN after its ack; the gap cycle has passed, issue the read.
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            maddr_q <= cpu_addr;
          end else begin
            state <= IDLE;
          end
        end
        LOAD_DONE: begin
          if (count != '0) begin
            state    <= DRAIN;
            req_q    <= 1'b1;
            we_q     <= 1'b1;
            maddr_q  <= addr_q[head];
            mwdata_q <= data_q[head];
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a latency-programmable memory model.
// Ports: drives cpu_* and the slave side of the memory bus; observes all outputs.
// Inputs change at negedge+1, outputs are sampled a further #1 later.
module tb_dmem_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  wire  [31:0] cpu_rdata;
  wire         cpu_stall;
  wire  [2:0]  wb_count;
  wire         wb_empty;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          lat;
  bit          mem_en;
  logic        auto_ack = 1'b0;
  logic        man_ack;
  int          wait_cnt = 0;
  logic [31:0] mem_arr [logic [31:0]];

  dmem_store_buffer_if #(.AW(32), .DW(32)) mif ();

  dmem_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem       (mif.master),
    .wb_count  (wb_count),
    .wb_empty  (wb_empty)
  );

  always #5 clock = ~clock;

  assign mif.mem_ack = mem_en ? auto_ack : man_ack;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    if (a == 32'h200) return 32'h55;
    if (a == 32'h400) return 32'h77;
    return 32'h0;
  endfunction

  // Ack arrives in the lat-th cycle that mem_req is seen high.
  initial mif.mem_rdata = '0;
  always @(negedge clock) begin
    if (!reset || !mem_en) begin
      wait_cnt = 0;
      auto_ack = 1'b0;
    end else if (auto_ack) begin
      auto_ack = 1'b0;
    end else if (mif.mem_req) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        wait_cnt = 0;
        auto_ack = 1'b1;
        if (!mif.mem_we) mif.mem_rdata = rd_val(mif.mem_addr);
      end
    end
  end

  always @(posedge clock) begin
    if (reset && mif.mem_req && mif.mem_ack && mif.mem_we)
      mem_arr[mif.mem_addr] = mif.mem_wdata;
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic drain_all(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wb_empty && !mif.mem_req) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", mif.mem_req); end
    n_checks++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", mif.mem_we); end
    n_checks++; if (mif.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", mif.mem_addr); end
    n_checks++; if (mif.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", mif.mem_wdata); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", cpu_rdata); end
    n_checks++; if (wb_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", wb_count); end
    n_checks++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", wb_empty); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", cpu_stall); end
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  // Store retires immediately; FSM sees it one cycle later, request is registered the cycle after.
  task automatic test_store_drain();
    mem_en = 1'b1; lat = 2;
    cpu_wr = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL st_stall got %b want 0", cpu_stall); end
    cyc(); cpu_wr = 1'b0; #1;
    n_checks++; if (wb_count !== 3'd1) begin n_fail++; $display("FAIL st_count1 got %0d want 1", wb_count); end
    cyc();
    n_checks++; if ({mif.mem_req, mif.mem_we} !== 2'b11) begin n_fail++; $display("FAIL st_req got %b want 11", {mif.mem_req, mif.mem_we}); end
    n_checks++; if (mif.mem_addr !== 32'h100) begin n_fail++; $display("FAIL st_addr got %h want 100", mif.mem_addr); end
    n_checks++; if (mif.mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_wdata got %h want deadbeef", mif.mem_wdata); end
    cyc();
    n_checks++; if (wb_count !== 3'd1) begin n_fail++; $display("FAIL st_count_hold got %0d want 1", wb_count); end
    cyc();
    n_checks++; if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin n_fail++; $display("FAIL st_count0 got %0d/%b want 0/1", wb_count, wb_empty); end
    n_checks++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL st_req_drop got %b want 0", mif.mem_req); end
    n_checks++; if (rd_val(32'h100) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_mem got %h want deadbeef", rd_val(32'h100)); end
  endtask

  task automatic test_forward();
    bit ok;
    mem_en = 1'b0;
    cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1; #1;
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL fw_st1 got %b want 0", cpu_stall); end
    cyc(); cpu_wdata = 32'h2; #1;
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL fw_st2 got %b want 0", cpu_stall); end
    cyc(); cpu_wr = 1'b0; cpu_rd = 1'b1; #1;
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL fw_ld_stall got %b want 0", cpu_stall); end
    n_checks++; if (cpu_rdata !== 32'h2) begin n_fail++; $display("FAIL fw_ld_data got %h want 2", cpu_rdata); end
    n_checks++; if (wb_count !== 3'd2) begin n_fail++; $display("FAIL fw_count got %0d want 2", wb_count); end
    // rd and wr together: served as a load, store dropped.
    cyc(); cpu_wr = 1'b1; cpu_wdata = 32'h99; #1;
    n_checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h2) begin n_fail++; $display("FAIL fw_rdwr got %b/%h want 0/2", cpu_stall, cpu_rdata); end
    cyc(); cpu_wr = 1'b0; cpu_rd = 1'b0; #1;
    n_checks++; if (wb_count !== 3'd2) begin n_fail++; $display("FAIL fw_rdwr_count got %0d want 2", wb_count); end
    mem_en = 1'b1; lat = 1;
    drain_all(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fw_drain_timeout count %0d want 0", wb_count); end
    n_checks++; if (rd_val(32'h10) !== 32'h2) begin n_fail++; $display("FAIL fw_mem got %h want 2", rd_val(32'h10)); end
  endtask

  task automatic test_full();
    bit ok;
    mem_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_wr = 1'b1; cpu_addr = 32'h20 + 32'(4 * i); cpu_wdata = 32'hA0 + 32'(i); #1;
      if (i < 4) begin
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL full_st%0d got %b want 0", i, cpu_stall); end
        cyc();
      end else begin
        n_checks++; if (cpu_stall !== 1'b1 || wb_count !== 3'd4) begin n_fail++; $display("FAIL full_st4 got %b/%0d want 1/4", cpu_stall, wb_count); end
      end
    end
    cyc();
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL full_hold got %b want 1", cpu_stall); end
    man_ack = 1'b1; #1;
    n_checks++; if (cpu_stall !== 1'b0 || wb_count !== 3'd4) begin n_fail++; $display("FAIL full_ack got %b/%0d want 0/4", cpu_stall, wb_count); end
    cyc(); man_ack = 1'b0; cpu_wr = 1'b0; #1;
    n_checks++; if (wb_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", wb_count); end
    n_checks++; if (rd_val(32'h20) !== 32'hA0) begin n_fail++; $display("FAIL full_mem0 got %h want a0", rd_val(32'h20)); end
    n_checks++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL full_gap got %b want 0", mif.mem_req); end
    cyc();
    n_checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h24 || mif.mem_wdata !== 32'hA1) begin
      n_fail++; $display("FAIL full_next got %b/%h/%h want 1/24/a1", mif.mem_req, mif.mem_addr, mif.mem_wdata); end
    mem_en = 1'b1; lat = 1;
    drain_all(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_drain_timeout count %0d want 0", wb_count); end
    n_checks++; if (rd_val(32'h2C) !== 32'hA3 || rd_val(32'h30) !== 32'hA4) begin
      n_fail++; $display("FAIL full_mem got %h/%h want a3/a4", rd_val(32'h2C), rd_val(32'h30)); end
  endtask

  task automatic test_load_miss();
    int  stalls = 0;
    bit  saw_read = 1'b0;
    mem_en = 1'b1; lat = 3;
    cpu_rd = 1'b1; cpu_addr = 32'h200;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (mif.mem_req && !mif.mem_we && mif.mem_addr == 32'h200) saw_read = 1'b1;
      if (!cpu_stall) break;
      stalls++;
      @(negedge clock);
    end
    n_checks++; if (stalls != 4) begin n_fail++; $display("FAIL lm_stalls got %0d want 4", stalls); end
    n_checks++; if (cpu_rdata !== 32'h55) begin n_fail++; $display("FAIL lm_data got %h want 55", cpu_rdata); end
    n_checks++; if (!saw_read) begin n_fail++; $display("FAIL lm_read got 0 want 1"); end
    cyc(); cpu_rd = 1'b0; #1;
    n_checks++; if (cpu_stall !== 1'b0 || mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL lm_after got %b/%b want 0/0", cpu_stall, mif.mem_req); end
  endtask

  task automatic test_miss_mid_drain();
    int          stalls = 0;
    bit          ok;
    bit          seen = 1'b0;
    logic [2:0]  cnt_at_read = '0;
    logic [31:0] m300_at_read = '0;
    mem_en = 1'b1; lat = 3;
    cpu_wr = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h1;
    cyc(); cpu_addr = 32'h304; cpu_wdata = 32'h2;
    cyc(); cpu_addr = 32'h300; cpu_wdata = 32'h3;
    cyc(); cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h400;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!seen && mif.mem_req && !mif.mem_we) begin
        seen = 1'b1; cnt_at_read = wb_count; m300_at_read = rd_val(32'h300);
      end
      if (!cpu_stall) break;
      stalls++;
      @(negedge clock);
    end
    n_checks++; if (stalls != 6) begin n_fail++; $display("FAIL md_stalls got %0d want 6", stalls); end
    n_checks++; if (cpu_rdata !== 32'h77) begin n_fail++; $display("FAIL md_data got %h want 77", cpu_rdata); end
    n_checks++; if (!seen || cnt_at_read !== 3'd2 || m300_at_read !== 32'h1) begin
      n_fail++; $display("FAIL md_order got %b/%0d/%h want 1/2/1", seen, cnt_at_read, m300_at_read); end
    cyc(); cpu_rd = 1'b0;
    drain_all(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL md_drain_timeout count %0d want 0", wb_count); end
    n_checks++; if (rd_val(32'h300) !== 32'h3 || rd_val(32'h304) !== 32'h2) begin
      n_fail++; $display("FAIL md_mem got %h/%h want 3/2", rd_val(32'h300), rd_val(32'h304)); end
  endtask

  task automatic test_reset_mid_load();
    mem_en = 1'b0;
    cpu_wr = 1'b1; cpu_addr = 32'h600; cpu_wdata = 32'h9;
    cyc(); cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h500;
    cyc();
    n_checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0 || mif.mem_addr !== 32'h500 || cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL rl_load got %b/%b/%h/%b want 1/0/500/1", mif.mem_req, mif.mem_we, mif.mem_addr, cpu_stall); end
    reset = 1'b0; #1;
    n_checks++; if (mif.mem_req !== 1'b0 || wb_empty !== 1'b1 || wb_count !== 3'd0) begin
      n_fail++; $display("FAIL rl_async got %b/%b/%0d want 0/1/0", mif.mem_req, wb_empty, wb_count); end
    cpu_rd = 1'b0; #1;
    n_checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rl_stall got %b/%h want 0/0", cpu_stall, cpu_rdata); end
    @(negedge clock); reset = 1'b1;
    cyc(); cyc();
    n_checks++; if (mif.mem_req !== 1'b0 || wb_empty !== 1'b1) begin n_fail++; $display("FAIL rl_idle got %b/%b want 0/1", mif.mem_req, wb_empty); end
  endtask

  initial begin
    reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_en = 1'b1; lat = 2; man_ack = 1'b0;
    #12;
    test_reset();
    test_store_drain();
    test_forward();
    test_full();
    test_load_miss();
    test_miss_mid_drain();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
